prio_arbiter: RTL and testbench
===============================

# prio_arbiter

Parametrised, registered N-way priority arbiter: the sequential successor to the team's 8-to-3 combinational priority encoder. It accepts N request lines and issues a one-hot grant plus a binary index and a valid flag. A grant is held while its requester keeps asserting. Selectable fixed-priority or round-robin mode, with an optional hold limit so that one requester cannot starve the others. It sits between multiple requesters and a shared resource (bus, port, memory bank).

## Interface
- N, 8: number of requesters, 2..32
- W, $clog2(N): width of gnt_idx (derived; do not override)
- MODE, 0: 0 = fixed priority (highest index wins); 1 = round-robin
- MAX_HOLD, 0: maximum consecutive grant cycles while others request; 0 = unlimited
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- req  input  N  request lines; bit i = requester i
- gnt  output  N  one-hot grant; all-zero when no grant
- gnt_idx  output  W  binary index of current/last owner
- gnt_valid  output  1  1 when gnt is non-zero

## Operation
- All outputs are registered. Internal state: owner index, gnt_valid, round-robin pointer, hold counter.
- States:
  - IDLE: gnt_valid = 0.
  - GRANTED: gnt_valid = 1, owner = gnt_idx.
- Arbitration happens at an edge when any of these hold:
  - state is IDLE;
  - req[owner] = 0;
  - the hold limit has expired.
- At an arbitration edge:
  - If a candidate exists, load winner into gnt/gnt_idx and enter GRANTED.
  - If no candidate exists, enter IDLE with gnt = 0; gnt_idx keeps its last value.
- In GRANTED with req[owner] = 1 and no hold expiry: gnt is held unchanged; other requests are ignored.
- Fixed mode: the highest set index wins. Behaviour is identical to the 8-to-3 encoder, with a registered output.
- Round-robin mode:
  - Search starts at (ptr) and descends, wrapping N-1 after 0.
  - After granting k, ptr = (k-1) mod N.
  - ptr resets to N-1, so the first round-robin grant matches fixed mode.
- Hold limit (MAX_HOLD > 0):
  - The counter increments every GRANTED cycle with an unchanged owner and clears on owner change.
  - When the owner has held for MAX_HOLD cycles and any other req bit is set, arbitration runs with the owner masked out.
  - If no other requester exists, the owner keeps the grant and the counter restarts at 1.
- The counter width is sized for MAX_HOLD. With MAX_HOLD = 0, the counter and hold logic are unused.
- gnt is always one-hot or zero, and gnt[gnt_idx] = gnt_valid.

## Timing
- Reset values: gnt = 0, gnt_idx = 0, gnt_valid = 0, ptr = N-1, counter = 0.
- rst has priority over all other inputs. Asserted mid-grant, all outputs clear at the next edge with no partial grant.
- Latency:
  - req rising with the arbiter IDLE → gnt at the next edge (1 cycle).
  - Owner dropping req, sampled low at edge t → new winner loaded at edge t, with no idle bubble if others are requesting.
- Requests asserted and released between edges are not seen; req is sampled only at rising edges.
- Simultaneous owner drop and hold expiry: treated as an owner drop; the owner is excluded because its req is 0.
- Wrap-around: ptr = 0 search order is 0, N-1, N-2, …, 1.

## Test plan
- Fixed mode, N=8, req=8'b0000_0101 → after 1 edge gnt=8'b0000_0100, gnt_idx=2, gnt_valid=1; held 5 cycles with req unchanged.
- Fixed mode, walking one 8'h01→8'h80, each held 3 cycles → gnt_idx steps 0..7 one cycle behind req; gnt always one-hot.
- Fixed mode, req=8'h81 → grant 7; clear bit 7 → at that same edge gnt=8'h01, gnt_valid stays 1 throughout.
- MODE=1, MAX_HOLD=4, req=8'hFF constant → grants 7,6,5,4,3,2,1,0,7, each exactly 4 cycles, with no gap.
- MODE=1, MAX_HOLD=4, req=8'h10 for 12 cycles → gnt=8'h10 continuously; then req=0 → gnt_valid=0 next edge, gnt_idx stays 4.
- rst asserted for 1 cycle while index 3 is granted in MODE=1 → next edge all outputs zero. Then with rst released and req=8'h09 → grant index 3, confirming ptr reset to N-1.

Source files
------------

// File: rtl/prio_arbiter.sv
`default_nettype none
// ============================================================================
// prio_arbiter : registered N-way arbiter, fixed priority or round-robin,
//                with an optional per-owner hold limit.
// Revision     : 1.0
// ============================================================================
module prio_arbiter #(
  parameter int N        = 8,
  parameter int W        = $clog2(N),
  parameter int MODE     = 0,
  parameter int MAX_HOLD = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_valid
);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_GRANTED = 1'b1
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [N-1:0] r_gnt;
  logic [N-1:0] w_gnt_nxt;
  logic [W-1:0] r_idx;
  logic [W-1:0] w_idx_nxt;
  logic [W-1:0] w_win;
  logic [N-1:0] w_cand;
  logic         w_found;
  logic         w_arb;
  logic         w_load;
  logic         w_expire;

  // On hold expiry the current owner is masked out of the candidate set.
  assign w_cand  = req & ~(w_expire ? r_gnt : '0);
  assign w_found = |w_cand;
  assign w_arb   = (r_state == S_IDLE) || !req[r_idx] || w_expire;
  assign w_load  = w_arb && w_found;

  if (MODE == 0) begin : g_fixed
    always_comb begin
      w_win = '0;
      for (int i = 0; i < N; i++) begin
        if (w_cand[i]) w_win = W'(i);
      end
    end
  end else begin : g_rr
    logic [W-1:0] r_ptr;
    logic [W-1:0] w_j;
    logic         w_hit;

    // Descending search from r_ptr, wrapping from 0 back to N-1.
    always_comb begin
      w_win = r_ptr;
      w_j   = r_ptr;
      w_hit = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!w_hit && w_cand[w_j]) begin
          w_win = w_j;
          w_hit = 1'b1;
        end
        w_j = (w_j == '0) ? W'(N - 1) : w_j - 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_ptr <= W'(N - 1);
      end else if (w_load) begin
        r_ptr <= (w_win == '0) ? W'(N - 1) : w_win - 1'b1;
      end
    end
  end

  if (MAX_HOLD > 0) begin : g_hold
    localparam int CW = $clog2(MAX_HOLD + 1);
    logic [CW-1:0] r_cnt;

    assign w_expire = (r_state == S_GRANTED) && (r_cnt == CW'(MAX_HOLD)) &&
                      (|(req & ~r_gnt));

    // A lone requester at the limit keeps the grant and restarts at 1.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt <= '0;
      end else if (w_load) begin
        r_cnt <= CW'(1);
      end else if (w_state_nxt == S_IDLE) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(MAX_HOLD)) begin
        r_cnt <= CW'(1);
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end else begin : g_nohold
    assign w_expire = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_idx_nxt   = r_idx;
    if (w_arb) begin
      if (w_found) begin
        w_state_nxt = S_GRANTED;
        w_gnt_nxt   = N'(1) << w_win;
        w_idx_nxt   = w_win;
      end else begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
      end
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_idx;
  assign gnt_valid = (r_state == S_GRANTED);

endmodule
`default_nettype wire

// File: tb/tb_prio_arbiter.sv
`default_nettype none
// ============================================================================
// tb_prio_arbiter : directed and randomized checks of four arbiter configs.
// Revision        : 1.0
// ============================================================================
module tb_prio_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_a, gnt_a;
  logic [2:0] idx_a;
  logic       val_a;
  logic [7:0] req_b, gnt_b;
  logic [2:0] idx_b;
  logic       val_b;
  logic [4:0] req_c, gnt_c;
  logic [2:0] idx_c;
  logic       val_c;
  logic [5:0] req_d, gnt_d;
  logic [2:0] idx_d;
  logic       val_d;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state per instance: a=fixed, b=rr/hold4, c=rr/hold2 N=5, d=fixed/hold3 N=6
  int m_n[4]    = '{8, 8, 5, 6};
  int m_mode[4] = '{0, 1, 1, 0};
  int m_mh[4]   = '{0, 4, 2, 3};
  int m_owner[4];
  int m_ptr[4];
  int m_cnt[4];
  bit m_valid[4];

  always #5 clk = ~clk;

  prio_arbiter #(.N(8), .MODE(0), .MAX_HOLD(0)) u_a (
    .clk(clk), .rst(rst), .req(req_a), .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(val_a));
  prio_arbiter #(.N(8), .MODE(1), .MAX_HOLD(4)) u_b (
    .clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(val_b));
  prio_arbiter #(.N(5), .MODE(1), .MAX_HOLD(2)) u_c (
    .clk(clk), .rst(rst), .req(req_c), .gnt(gnt_c), .gnt_idx(idx_c), .gnt_valid(val_c));
  prio_arbiter #(.N(6), .MODE(0), .MAX_HOLD(3)) u_d (
    .clk(clk), .rst(rst), .req(req_d), .gnt(gnt_d), .gnt_idx(idx_d), .gnt_valid(val_d));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] req_of(input int k);
    case (k)
      0:       return 32'(req_a);
      1:       return 32'(req_b);
      2:       return 32'(req_c);
      default: return 32'(req_d);
    endcase
  endfunction

  task automatic get_obs(input int k, output logic [31:0] g, output logic [31:0] ix,
                         output logic [31:0] v);
    case (k)
      0:       begin g = 32'(gnt_a); ix = 32'(idx_a); v = 32'(val_a); end
      1:       begin g = 32'(gnt_b); ix = 32'(idx_b); v = 32'(val_b); end
      2:       begin g = 32'(gnt_c); ix = 32'(idx_c); v = 32'(val_c); end
      default: begin g = 32'(gnt_d); ix = 32'(idx_d); v = 32'(val_d); end
    endcase
  endtask

  task automatic model_update(input int k, input logic [31:0] r, input logic rs);
    int  n;
    int  win;
    int  excl;
    int  idx;
    bit  arb;
    bit  others;
    n    = m_n[k];
    win  = -1;
    excl = -1;
    if (rs) begin
      m_valid[k] = 1'b0;
      m_owner[k] = 0;
      m_ptr[k]   = n - 1;
      m_cnt[k]   = 0;
      return;
    end
    others = (r & ~(32'd1 << m_owner[k])) != 0;
    arb    = !m_valid[k] || !r[m_owner[k]];
    if (!arb && m_mh[k] > 0 && m_cnt[k] >= m_mh[k] && others) begin
      arb  = 1'b1;
      excl = m_owner[k];
    end
    if (arb) begin
      for (int s = 0; s < n; s++) begin
        idx = (m_mode[k] != 0) ? (m_ptr[k] - s + n) % n : n - 1 - s;
        if (win < 0 && r[idx] && idx != excl) win = idx;
      end
      if (win >= 0) begin
        m_valid[k] = 1'b1;
        m_owner[k] = win;
        m_cnt[k]   = 1;
        m_ptr[k]   = (win + n - 1) % n;
      end else begin
        m_valid[k] = 1'b0;
        m_cnt[k]   = 0;
      end
    end else if (m_mh[k] > 0) begin
      m_cnt[k] = (m_cnt[k] >= m_mh[k]) ? 1 : m_cnt[k] + 1;
    end
  endtask

  task automatic step();
    logic [31:0] g, ix, v;
    @(posedge clk);
    for (int k = 0; k < 4; k++) model_update(k, req_of(k), rst);
    #1;
    for (int k = 0; k < 4; k++) begin
      get_obs(k, g, ix, v);
      check($sformatf("gnt[%0d]", k), g, m_valid[k] ? (32'd1 << m_owner[k]) : 32'd0);
      check($sformatf("gnt_idx[%0d]", k), ix, 32'(m_owner[k]));
      check($sformatf("gnt_valid[%0d]", k), v, 32'(m_valid[k]));
      check($sformatf("onehot[%0d]", k), 32'($countones(g) <= 1), 32'd1);
    end
  endtask

  initial begin
    rst   = 1'b1;
    req_a = '0;
    req_b = '0;
    req_c = '0;
    req_d = '0;
    step();
    step();
    check("rst_gnt_a", 32'(gnt_a), 32'h0);
    check("rst_idx_b", 32'(idx_b), 32'h0);
    check("rst_valid_b", 32'(val_b), 32'h0);
    rst = 1'b0;

    req_a = 8'h05;
    step();
    check("a_gnt_05", 32'(gnt_a), 32'h04);
    check("a_idx_05", 32'(idx_a), 32'd2);
    check("a_val_05", 32'(val_a), 32'd1);
    repeat (5) begin
      step();
      check("a_hold_05", 32'(gnt_a), 32'h04);
    end

    for (int b = 0; b < 8; b++) begin
      req_a = 8'h01 << b;
      step();
      check("a_walk_idx", 32'(idx_a), 32'(b));
      step();
      step();
    end

    req_a = 8'h81;
    step();
    check("a_81_idx", 32'(idx_a), 32'd7);
    req_a = 8'h01;
    step();
    check("a_drop_gnt", 32'(gnt_a), 32'h01);
    check("a_drop_val", 32'(val_a), 32'd1);

    rst = 1'b1;
    step();
    rst   = 1'b0;
    req_b = 8'hFF;
    for (int s = 0; s < 36; s++) begin
      step();
      check("b_rr_idx", 32'(idx_b), 32'(7 - (s / 4) % 8));
      check("b_rr_val", 32'(val_b), 32'd1);
    end

    req_b = 8'h10;
    repeat (12) begin
      step();
      check("b_lone_gnt", 32'(gnt_b), 32'h10);
    end
    req_b = 8'h00;
    step();
    check("b_idle_val", 32'(val_b), 32'd0);
    check("b_idle_idx", 32'(idx_b), 32'd4);

    req_b = 8'h08;
    step();
    check("b_pre_rst_idx", 32'(idx_b), 32'd3);
    rst = 1'b1;
    step();
    check("b_rst_gnt", 32'(gnt_b), 32'h0);
    check("b_rst_idx", 32'(idx_b), 32'h0);
    check("b_rst_val", 32'(val_b), 32'h0);
    rst   = 1'b0;
    req_b = 8'h09;
    step();
    check("b_ptr_reset_idx", 32'(idx_b), 32'd3);

    // Sticky random requests so holds and expiries actually occur.
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 2) == 0)
        req_a = $urandom_range(0, 1) ? 8'($urandom) : 8'($urandom & $urandom);
      if ($urandom_range(0, 2) == 0)
        req_b = $urandom_range(0, 1) ? 8'($urandom) : 8'($urandom & $urandom);
      if ($urandom_range(0, 2) == 0)
        req_c = $urandom_range(0, 1) ? 5'($urandom) : 5'($urandom & $urandom);
      if ($urandom_range(0, 2) == 0)
        req_d = $urandom_range(0, 1) ? 6'($urandom) : 6'($urandom & $urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
